// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 register indices, exception codes and CP0 helpers.
package cpu_defs;

    // CP0 register indices
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Exception codes carried in Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // The exception controller has two states; the state is SR.EXL itself
    typedef enum logic {
        ST_USER    = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_t;

    // SR image: IM in [15:10], EXL in [1], IE in [0], everything else zero
    function automatic logic [31:0] sr_pack(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        return {16'h0000, im, 8'h00, exl, ie};
    endfunction

    // Cause image: BD in [31], IP in [15:10], ExcCode in [6:2], everything else zero
    function automatic logic [31:0] cause_pack(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc_code);
        return {bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
    endfunction

    // Restart address: a delay-slot instruction restarts at its branch, always word aligned
    function automatic logic [31:0] epc_align(input logic [31:0] pc,
                                              input logic        bd);
        logic [31:0] raw;
        raw = bd ? (pc - 32'd4) : pc;
        return {raw[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause, EPC, PRId plus
// the exception entry / eret decision that redirects the fetch unit.
module cp0_exc_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] PRID    = 32'h2021_0707,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic        eret,
    output logic [31:0] rdata,
    output logic        int_req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc,
    output logic        exl
);

    // Architectural state
    cp0_state_t  state_r;
    logic [5:0]  sr_im_r;
    logic        sr_ie_r;
    logic        cause_bd_r;
    logic [5:0]  cause_ip_r;
    logic [4:0]  cause_exc_r;
    logic [31:0] epc_r;

    // Entry decision
    logic        exl_s;
    logic        irq_s;
    logic        exc_s;
    logic        int_req_s;
    logic [4:0]  entry_code_s;

    assign exl_s      = (state_r == ST_HANDLER);
    assign exl        = exl_s;
    assign epc_out    = epc_r;
    assign handler_pc = HANDLER;
    assign int_req    = int_req_s;

    // Decide whether to take an interrupt or exception this cycle; interrupts outrank exceptions
    always_comb begin
        irq_s        = 1'b0;
        exc_s        = 1'b0;
        int_req_s    = 1'b0;
        entry_code_s = EXC_INT;
        if (!exl_s) begin
            irq_s     = sr_ie_r & (|(hw_int & sr_im_r));
            exc_s     = m_valid & (exc_code_in != 5'd0);
            int_req_s = irq_s | exc_s;
            if (irq_s) begin
                entry_code_s = EXC_INT;
            end else begin
                entry_code_s = exc_code_in;
            end
        end else begin
            irq_s        = 1'b0;
            exc_s        = 1'b0;
            int_req_s    = 1'b0;
            entry_code_s = EXC_INT;
        end
    end

    // mfc0 read port: shows register contents before the coming edge
    always_comb begin
        rdata = 32'h0000_0000;
        case (cp0_addr)
            CP0_SR:    rdata = sr_pack(sr_im_r, exl_s, sr_ie_r);
            CP0_CAUSE: rdata = cause_pack(cause_bd_r, cause_ip_r, cause_exc_r);
            CP0_EPC:   rdata = epc_r;
            CP0_PRID:  rdata = PRID;
            default:   rdata = 32'h0000_0000;
        endcase
    end

    // USER/HANDLER state machine and CP0 register updates; entry beats eret beats mtc0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_USER;
            sr_im_r     <= 6'd0;
            sr_ie_r     <= 1'b0;
            cause_bd_r  <= 1'b0;
            cause_ip_r  <= 6'd0;
            cause_exc_r <= 5'd0;
            epc_r       <= 32'h0000_0000;
        end else begin
            cause_ip_r <= hw_int;
            if (int_req_s) begin
                state_r     <= ST_HANDLER;
                cause_exc_r <= entry_code_s;
                cause_bd_r  <= m_bd;
                epc_r       <= epc_align(m_pc, m_bd);
            end else if (eret) begin
                state_r <= ST_USER;
                // The handler may rewrite EPC in the same cycle as its eret
                if (mtc0_we && (cp0_addr == CP0_EPC)) begin
                    epc_r <= {wdata[31:2], 2'b00};
                end
            end else if (mtc0_we) begin
                case (cp0_addr)
                    CP0_SR: begin
                        sr_im_r <= wdata[15:10];
                        sr_ie_r <= wdata[0];
                        state_r <= wdata[1] ? ST_HANDLER : ST_USER;
                    end
                    CP0_EPC: begin
                        epc_r <= {wdata[31:2], 2'b00};
                    end
                    default: begin
                        // Cause and PRId are read-only to software
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] rdata;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
    logic        exl;

    int checks;
    int errors;

    cp0_exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_pc        (m_pc),
        .m_bd        (m_bd),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .wdata       (wdata),
        .eret        (eret),
        .rdata       (rdata),
        .int_req     (int_req),
        .epc_out     (epc_out),
        .handler_pc  (handler_pc),
        .exl         (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then step off it before touching inputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mtc0(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we  = 1'b1;
        cp0_addr = addr;
        wdata    = data;
        tick();
        mtc0_we  = 1'b0;
        wdata    = 32'h0000_0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cp0_addr = 5'd12; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL reset_sr got %h want %h", rdata, 32'h0); end
        cp0_addr = 5'd13; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL reset_cause got %h want %h", rdata, 32'h0); end
        cp0_addr = 5'd14; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL reset_epc got %h want %h", rdata, 32'h0); end
        cp0_addr = 5'd15; #1; checks++;
        if (rdata !== 32'h2021_0707) begin errors++; $display("FAIL reset_prid got %h want %h", rdata, 32'h2021_0707); end
        cp0_addr = 5'd3; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL unimpl_read got %h want %h", rdata, 32'h0); end
        checks++;
        if (int_req !== 1'b0 || exl !== 1'b0) begin errors++; $display("FAIL reset_ctrl got int_req=%b exl=%b want 0 0", int_req, exl); end
        checks++;
        if (handler_pc !== 32'h0000_4180) begin errors++; $display("FAIL handler_pc got %h want %h", handler_pc, 32'h4180); end
    endtask

    task automatic test_irq_entry();
        do_mtc0(5'd12, 32'h0000_0401);
        cp0_addr = 5'd12; #1; checks++;
        if (rdata !== 32'h0000_0401) begin errors++; $display("FAIL sr_write got %h want %h", rdata, 32'h401); end
        hw_int = 6'b000001; m_pc = 32'h0000_3010; m_bd = 1'b0; m_valid = 1'b1;
        #1; checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL irq_same_cycle got %b want 1", int_req); end
        tick();
        hw_int = 6'b000000; m_valid = 1'b0;
        cp0_addr = 5'd13; #1; checks++;
        if (rdata !== 32'h0000_0400) begin errors++; $display("FAIL irq_cause got %h want %h", rdata, 32'h400); end
        checks++;
        if (epc_out !== 32'h0000_3010) begin errors++; $display("FAIL irq_epc got %h want %h", epc_out, 32'h3010); end
        checks++;
        if (exl !== 1'b1 || int_req !== 1'b0) begin errors++; $display("FAIL irq_exl got exl=%b int_req=%b want 1 0", exl, int_req); end
        eret = 1'b1;
        tick();
        eret = 1'b0; #1; checks++;
        if (exl !== 1'b0 || epc_out !== 32'h0000_3010) begin errors++; $display("FAIL irq_eret got exl=%b epc=%h want 0 00003010", exl, epc_out); end
    endtask

    task automatic test_exc_bd();
        do_mtc0(5'd12, 32'h0000_0400);
        exc_code_in = 5'd12; m_pc = 32'h0000_3020; m_bd = 1'b1; m_valid = 1'b1;
        #1; checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL exc_same_cycle got %b want 1", int_req); end
        tick();
        exc_code_in = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
        cp0_addr = 5'd13; #1; checks++;
        if (rdata !== 32'h8000_0030) begin errors++; $display("FAIL exc_cause got %h want %h", rdata, 32'h8000_0030); end
        checks++;
        if (epc_out !== 32'h0000_301C) begin errors++; $display("FAIL exc_bd_epc got %h want %h", epc_out, 32'h301C); end
        checks++;
        if (exl !== 1'b1) begin errors++; $display("FAIL exc_exl got %b want 1", exl); end
    endtask

    task automatic test_no_nesting();
        do_mtc0(5'd12, 32'h0000_0403);
        hw_int = 6'b000001; exc_code_in = 5'd10; m_valid = 1'b1; m_pc = 32'h0000_3030;
        #1; checks++;
        if (int_req !== 1'b0) begin errors++; $display("FAIL nest_blocked got %b want 0", int_req); end
        tick();
        #1; checks++;
        if (exl !== 1'b1 || epc_out !== 32'h0000_301C) begin errors++; $display("FAIL nest_hold got exl=%b epc=%h want 1 0000301c", exl, epc_out); end
        hw_int = 6'b000000; exc_code_in = 5'd0; m_valid = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0; #1; checks++;
        if (exl !== 1'b0 || epc_out !== 32'h0000_301C || int_req !== 1'b0) begin
            errors++; $display("FAIL nest_eret got exl=%b epc=%h int_req=%b want 0 0000301c 0", exl, epc_out, int_req);
        end
    endtask

    task automatic test_priority();
        hw_int = 6'b000001; exc_code_in = 5'd4; m_valid = 1'b1; m_pc = 32'h0000_3040; m_bd = 1'b0;
        mtc0_we = 1'b1; cp0_addr = 5'd14; wdata = 32'h0000_1234;
        #1; checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL prio_req got %b want 1", int_req); end
        tick();
        mtc0_we = 1'b0; wdata = 32'h0; hw_int = 6'b000000; exc_code_in = 5'd0; m_valid = 1'b0;
        cp0_addr = 5'd13; #1; checks++;
        if (rdata !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause got %h want %h", rdata, 32'h400); end
        checks++;
        if (epc_out !== 32'h0000_3040) begin errors++; $display("FAIL prio_mtc0_dropped got %h want %h", epc_out, 32'h3040); end
    endtask

    task automatic test_eret_epc_write();
        eret = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; wdata = 32'h0000_5557;
        tick();
        eret = 1'b0; mtc0_we = 1'b0; wdata = 32'h0; #1; checks++;
        if (exl !== 1'b0 || epc_out !== 32'h0000_5554) begin errors++; $display("FAIL eret_epc got exl=%b epc=%h want 0 00005554", exl, epc_out); end
        do_mtc0(5'd13, 32'hFFFF_FFFF);
        cp0_addr = 5'd13; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL cause_ro got %h want %h", rdata, 32'h0); end
        do_mtc0(5'd15, 32'h0000_0000);
        cp0_addr = 5'd15; #1; checks++;
        if (rdata !== 32'h2021_0707) begin errors++; $display("FAIL prid_ro got %h want %h", rdata, 32'h2021_0707); end
    endtask

    task automatic test_reset_mid();
        hw_int = 6'b000001; m_pc = 32'h0000_3050; m_valid = 1'b0;
        #1; checks++;
        if (int_req !== 1'b1) begin errors++; $display("FAIL bubble_irq got %b want 1", int_req); end
        tick();
        #1; checks++;
        if (exl !== 1'b1 || epc_out !== 32'h0000_3050) begin errors++; $display("FAIL bubble_entry got exl=%b epc=%h want 1 00003050", exl, epc_out); end
        reset = 1'b1;
        tick();
        cp0_addr = 5'd12; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL midrst_sr got %h want %h", rdata, 32'h0); end
        cp0_addr = 5'd13; #1; checks++;
        if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL midrst_cause got %h want %h", rdata, 32'h0); end
        checks++;
        if (epc_out !== 32'h0000_0000 || exl !== 1'b0 || int_req !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got epc=%h exl=%b int_req=%b want 00000000 0 0", epc_out, exl, int_req);
        end
        reset = 1'b0; hw_int = 6'b000000;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; m_valid = 1'b0; m_pc = 32'h0; m_bd = 1'b0; exc_code_in = 5'd0;
        hw_int = 6'd0; mtc0_we = 1'b0; cp0_addr = 5'd0; wdata = 32'h0; eret = 1'b0;
        test_reset();
        test_irq_entry();
        test_exc_bd();
        test_no_nesting();
        test_priority();
        test_eret_epc_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
